// File: rtl/uart_tx_fifo.sv
// Transmit FIFO feeding a UART transmitter one byte per tx_start/tx_done_tick handshake.
// Optional sticky overflow flag enabled by defining UART_TX_FIFO_OVERFLOW_EN.
module uart_tx_fifo #(
  parameter int D_BITS    = 8,
  parameter int ADDR_BITS = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 wr_en,
  input  logic [D_BITS-1:0]    din,
  output logic                 full,
  output logic                 empty,
  output logic [ADDR_BITS:0]   count,
  output logic [D_BITS-1:0]    tx_din,
  output logic                 tx_start,
  input  logic                 tx_done_tick,
`ifdef UART_TX_FIFO_OVERFLOW_EN
  output logic                 overflow,
  input  logic                 clr_overflow,
`endif
  output logic                 busy
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS:0]   DEPTH_CNT = (ADDR_BITS+1)'(DEPTH);
  localparam logic [ADDR_BITS:0]   CNT_ONE   = (ADDR_BITS+1)'(1);
  localparam logic [ADDR_BITS-1:0] PTR_ONE   = ADDR_BITS'(1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [D_BITS-1:0]    mem [DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr;
  logic [ADDR_BITS-1:0] rd_ptr;
  logic [0:0]           state;
  logic                 push;
  logic                 pop;

  assign full  = (count == DEPTH_CNT);
  assign empty = (count == '0);
  assign busy  = (state == BUSY);

  // Both decisions use the pre-edge occupancy, so a pop never frees room for a same-cycle write.
  assign push = wr_en && !full;
  assign pop  = (state == IDLE) && !empty;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      tx_din   <= '0;
      tx_start <= 1'b0;
      state    <= IDLE;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end

      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase

      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            tx_din   <= mem[rd_ptr];
            rd_ptr   <= rd_ptr + PTR_ONE;
            tx_start <= 1'b1;
            state    <= BUSY;
          end
        end
        default: begin
          if (tx_done_tick) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

`ifdef UART_TX_FIFO_OVERFLOW_EN
  // A dropped write in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (wr_en && full) begin
      overflow <= 1'b1;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
    end
  end
`endif

endmodule
